// File: rtl/pwm_bank_pkg.sv
// Shared definitions for the pwm_bank pulse generator: channel modes and the
// per-channel state record.
package pwm_bank_pkg;

   localparam logic PWM_ONESHOT = 1'b0;
   localparam logic PWM_COMPARE = 1'b1;

   // Channel words are stored zero-extended to this width; WIDTH must not exceed it.
   localparam int PWM_MAX_WIDTH = 16;

   typedef logic [PWM_MAX_WIDTH-1:0] pwm_word_t;

   typedef struct packed {
      logic      mode;
      pwm_word_t cnt;
      pwm_word_t duty_act;
      pwm_word_t duty_pend;
      logic      pend;
      logic      pw;
   } pwm_chan_state_t;

endpackage

// File: rtl/pwm_bank_chan.sv
// One pwm_bank channel: a one-shot down-counter or a double-buffered duty
// comparator against the shared phase, selected per load.
module pwm_bank_chan
   import pwm_bank_pkg::*;
#(
   parameter int WIDTH = 7
) (
   input  logic             MasterClock,
   input  logic             reset,
   input  logic             tick,
   input  logic             wrap,
   input  logic [WIDTH-1:0] phase,
   input  logic             ld,
   input  logic             ld_mode,
   input  logic [WIDTH-1:0] ld_data,
   output logic             pw,
   output logic             busy,
   output logic             done
);

   pwm_chan_state_t st;
   logic            done_q;

   always_ff @(posedge MasterClock) begin
      if (reset) begin
         st     <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (ld) begin
            // A load owns this cycle: pw holds, and a load on the wrap tick
            // goes straight into the active duty.
            st.mode <= ld_mode;
            if (ld_mode == PWM_ONESHOT) begin
               st.cnt  <= pwm_word_t'(ld_data);
               st.pend <= 1'b0;
            end else begin
               st.cnt       <= '0;
               st.duty_pend <= pwm_word_t'(ld_data);
               if (tick && wrap) begin
                  st.duty_act <= pwm_word_t'(ld_data);
                  st.pend     <= 1'b0;
               end else begin
                  st.pend <= 1'b1;
               end
            end
         end else if (tick) begin
            if (st.mode == PWM_ONESHOT) begin
               if (st.cnt != '0) begin
                  st.cnt <= st.cnt - pwm_word_t'(1);
                  st.pw  <= 1'b1;
                  done_q <= (st.cnt == pwm_word_t'(1));
               end else begin
                  st.pw <= 1'b0;
               end
            end else begin
               st.pw <= (pwm_word_t'(phase) < st.duty_act);
               if (wrap && st.pend) begin
                  st.duty_act <= st.duty_pend;
                  st.pend     <= 1'b0;
               end
            end
         end
      end
   end

   assign pw   = st.pw;
   assign busy = (st.cnt != '0);
   assign done = done_q;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel pulse-width generator: shared tick-driven phase counter, load
// decode, and one pwm_bank_chan per output.
module pwm_bank
   import pwm_bank_pkg::*;
#(
   parameter int WIDTH    = 7,
   parameter int CHANNELS = 4,
   parameter int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                MasterClock,
   input  logic                reset,
   input  logic                xck_en,
   input  logic                ld,
   input  logic [CH_BITS-1:0]  ld_ch,
   input  logic                ld_mode,
   input  logic [WIDTH-1:0]    ld_data,
   output logic [CHANNELS-1:0] pw,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] done
);

   logic [WIDTH-1:0] phase;
   logic             wrap;

   always_ff @(posedge MasterClock) begin
      if (reset) begin
         phase <= '0;
      end else if (xck_en) begin
         phase <= phase + WIDTH'(1);
      end
   end

   assign wrap = &phase;

   // Indices at or above CHANNELS match no instance, so such loads are dropped.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      logic ld_sel;
      assign ld_sel = ld && (ld_ch == CH_BITS'(i));

      pwm_bank_chan #(.WIDTH(WIDTH)) u_chan (
         .MasterClock (MasterClock),
         .reset       (reset),
         .tick        (xck_en),
         .wrap        (wrap),
         .phase       (phase),
         .ld          (ld_sel),
         .ld_mode     (ld_mode),
         .ld_data     (ld_data),
         .pw          (pw[i]),
         .busy        (busy[i]),
         .done        (done[i])
      );
   end

endmodule

// File: doc/pwm_bank.md
# pwm_bank

Multi-channel, parametrised pulse-width generator for the Slipstream audio/output path. It is the successor to the single 7-bit load-and-count-down pulse counter. Each channel runs in one of two modes:
- **One-shot:** load a count; the output stays high for exactly that many ticks.
- **Compare (periodic PWM):** the output is high for `duty` ticks out of every 2^WIDTH-tick period, against a shared free-running phase counter.

Channels are programmed through a single load port. All logic runs on `MasterClock`, and counting advances only on `xck_en` ticks.

## Interface
Parameters:
- `WIDTH`, 7: count/duty/phase width in bits (≥2).
- `CHANNELS`, 4: number of output channels (≥1).
- `CH_BITS`, `$clog2(CHANNELS)` (min 1): width of the channel index.

Ports:
- `MasterClock`, in, 1: single clock for the whole block.
- `reset`, in, 1: reset is synchronous and active-high.
- `xck_en`, in, 1: count tick enable (replaces the old XCK clock); one-cycle strobe.
- `ld`, in, 1: load strobe, sampled each `MasterClock`.
- `ld_ch`, in, CH_BITS: channel index for the load.
- `ld_mode`, in, 1: 0 = one-shot, 1 = compare.
- `ld_data`, in, WIDTH: count (one-shot) or duty (compare).
- `pw`, out, CHANNELS: registered, glitch-free pulse outputs.
- `busy`, out, CHANNELS: one-shot count non-zero (combinational from the channel register).
- `done`, out, CHANNELS: one-cycle pulse when a one-shot count reaches 0.

## Operation
- **Phase counter.** `phase` is WIDTH bits and shared by all channels. It increments on every tick and wraps from 2^WIDTH−1 to 0. The "wrap tick" is a tick taken while `phase` = 2^WIDTH−1.
- **Load** (`ld`=1 and `ld_ch` < CHANNELS; otherwise the load is ignored):
  - `mode[ch]` ← `ld_mode`.
  - One-shot: `cnt` ← `ld_data`; `pend` flag cleared.
  - Compare: `duty_pend` ← `ld_data`, `pend` ← 1, `cnt` ← 0. `duty_act` is retained.
- **One-shot mode, on each tick:**
  - If `cnt` ≠ 0: `cnt` ← `cnt`−1 and `pw` ← 1. If `cnt` = 1, `done` pulses in the next cycle.
  - If `cnt` = 0: `pw` ← 0.
  - Loading D therefore gives `pw` high for exactly D ticks. D = 0 gives no pulse.
- **Compare mode, on each tick:**
  - `pw` ← (`phase` < `duty_act`), unsigned compare using pre-tick values.
  - On the wrap tick, if `pend` is set: `duty_act` ← `duty_pend` and `pend` ← 0. This double buffering means a new duty is adopted only at a period boundary.
  - `duty` = 0 keeps `pw` low. `duty` = 2^WIDTH−1 holds `pw` high for all but one tick per period.
  - `done` and `busy` stay at 0.
- **Simultaneous load and tick on the same channel:**
  - The load wins for `cnt`, `mode` and `duty_pend`. That channel's `pw` holds its value for that cycle.
  - If that tick is also the wrap tick and `ld_mode` = 1, `duty_act` ← `ld_data` directly and `pend` ← 0.
  - Other channels tick normally.
- **Reload mid-pulse.** Loading a one-shot channel while it is counting restarts it from the new value, with no `done` for the aborted count.
- **Reset** (synchronous, priority over everything): `phase`, `cnt`, `duty_act`, `duty_pend`, `pend`, `mode` ← 0. Outputs `pw` = 0, `busy` = 0, `done` = 0.

## Timing
- Load to effect: registered at the first `MasterClock` edge with `ld`=1. `busy` rises in the following cycle.
- Tick to `pw`: 1 cycle. `pw` changes only in the cycle after an `xck_en` edge (or on reset).
- `done` is exactly one `MasterClock` cycle wide, in the cycle after the tick that takes `cnt` from 1 to 0. It coincides with the last `pw`=1 cycle.
- `xck_en` held high continuously is legal: every cycle is then a tick.
- Compare-mode period is 2^WIDTH ticks. A duty change seen at `pw` is delayed by up to 2^WIDTH ticks plus 1 cycle.

## Structure
- Package `pwm_bank_pkg`:
  - mode constants `PWM_ONESHOT` = 1'b0 and `PWM_COMPARE` = 1'b1;
  - a channel-state struct typedef (mode, cnt, duty_act, duty_pend, pend, pw).
- Sub-module `pwm_bank_chan`:
  - one per channel, generated CHANNELS times;
  - inputs: `MasterClock`, `reset`, `tick`, `wrap`, `phase`, and a per-channel load qualifier;
  - outputs: `pw`, `busy`, `done`.
- Top level holds the phase counter, load decode, and the generate loop.

## Test plan
- **One-shot:** reset, then load ch0 D=3 in one-shot, tick every 4th cycle → `pw[0]` high for exactly 3 ticks, a single `done[0]` pulse on the 3rd, then `busy[0]`=0. Load D=0 → `pw` never rises.
- **Compare:** WIDTH=4, load ch1 duty=5, tick every cycle → after the first wrap, `pw[1]` is high for 5 of every 16 cycles. Duty 0 → always low. Duty 15 → low 1 cycle of 16.
- **Double buffer:** in compare at duty=4, load duty=12 mid-period → the current period still shows 4, and the next period shows 12. A load coinciding with the wrap tick → the new duty takes effect in the immediately following period.
- **Simultaneous load and tick:** load ch2 D=2 on the same cycle as a tick → `cnt` = 2, `pw[2]` unchanged that cycle, then high for 2 further ticks. Reload D=5 mid-count → no `done`, and the pulse restarts.
- **Reset and bad index:** synchronous reset mid-pulse (ch0 `cnt`=5) → next cycle all outputs are 0 and `phase` = 0. `ld_ch` = CHANNELS (non-power-of-2 config, CHANNELS=3) → no channel changes.
